mem_port_arbiter: RTL and testbench

Shares the single-ported unified instruction/data memory between the IF stage (fetch port) and the MEM stage (data port) of the 5-stage pipeline. Grants one access at a time over a fixed-latency memory and sequences it with a small FSM and wait counter. Produces per-port stall requests that the pipeline control combines with the hazard-unit stall and flush signals.

---
 rtl/mem_port_arbiter_if.sv | 36 +++
 rtl/mem_port_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Fetch/data request ports, memory-side strobes and stall outputs of the unified memory arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ready;
    logic              flush;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              stall_if;
    logic              stall_dm;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, flush, mem_rdata,
        output if_rdata, if_ready, dm_rdata, dm_ready,
        output mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_dm
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, flush, mem_rdata,
        input  if_rdata, if_ready, dm_rdata, dm_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_dm
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between fetch and data ports (data first).
// Request -> mem_en next cycle -> ready pulse WAIT_CYCLES+1 cycles after the request; stall_* held until ready.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    mem_port_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic {GNT_IF, GNT_DM} grant_t;

    state_t            state_q;
    grant_t            grant_q;
    logic              kill_q;
    logic              store_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;
    logic              if_ready_q;
    logic              dm_ready_q;
    logic              dm_go;
    logic              if_go;

    // A ready pulse marks the port just served; its still-held request must not be granted again.
    // A killed fetch produced no pulse, so a fresh fetch may be granted straight out of DONE.
    always_comb begin
        dm_go = bus.dm_req & ~dm_ready_q;
        if_go = bus.if_req & ~bus.flush & ~if_ready_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            grant_q     <= GNT_IF;
            kill_q      <= 1'b0;
            store_q     <= 1'b0;
            cnt_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if_ready_q <= 1'b0;
                    dm_ready_q <= 1'b0;
                    kill_q     <= 1'b0;
                    if (dm_go) begin
                        grant_q     <= GNT_DM;
                        store_q     <= bus.dm_we;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= bus.dm_we;
                        mem_addr_q  <= bus.dm_addr;
                        mem_wdata_q <= bus.dm_wdata;
                        cnt_q       <= CNT_LOAD;
                        state_q     <= BUSY;
                    end else if (if_go) begin
                        grant_q    <= GNT_IF;
                        store_q    <= 1'b0;
                        mem_en_q   <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= bus.if_addr;
                        cnt_q      <= CNT_LOAD;
                        state_q    <= BUSY;
                    end else begin
                        mem_en_q <= 1'b0;
                        mem_we_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                BUSY: begin
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    if (grant_q == GNT_IF && bus.flush) begin
                        kill_q <= 1'b1;
                    end
                    if (cnt_q == '0) begin
                        state_q <= DONE;
                        if (grant_q == GNT_IF) begin
                            if_rdata_q <= bus.mem_rdata;
                            if_ready_q <= ~(kill_q | bus.flush);
                        end else begin
                            dm_ready_q <= 1'b1;
                            if (!store_q) begin
                                dm_rdata_q <= bus.mem_rdata;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.dm_ready  = dm_ready_q;
    assign bus.stall_if  = bus.if_req & ~if_ready_q;
    assign bus.stall_dm  = bus.dm_req & ~dm_ready_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed per-cycle vectors for the memory arbiter: WAIT_CYCLES=2 instance plus a WAIT_CYCLES=1 instance.
module tb_mem_port_arbiter;
    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        dm_req;
        logic        dm_we;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
        logic        flush;
        logic [31:0] mem_rdata;
        logic        e_en;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_ifrdy;
        logic [31:0] e_ifd;
        logic        e_dmrdy;
        logic [31:0] e_dmd;
        logic        e_sif;
        logic        e_sdm;
    } vec_t;

    localparam logic [31:0] G = 32'hBAD0BAD0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    vec_t tbl[$];
    vec_t idle_v;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus2 ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(2)) u_dut2 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus2)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)) u_dut1 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus1)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(int ir, logic [31:0] ia, int dr, int dw, logic [31:0] da,
                               logic [31:0] dwd, int fl, logic [31:0] rd,
                               int en, int we, logic [31:0] addr, logic [31:0] wd,
                               int ird, logic [31:0] ifd, int drd, logic [31:0] dmd,
                               int si, int sd);
        vec_t r;
        r.if_req  = (ir != 0);  r.if_addr  = ia;
        r.dm_req  = (dr != 0);  r.dm_we    = (dw != 0);
        r.dm_addr = da;         r.dm_wdata = dwd;
        r.flush   = (fl != 0);  r.mem_rdata = rd;
        r.e_en    = (en != 0);  r.e_we     = (we != 0);
        r.e_addr  = addr;       r.e_wdata  = wd;
        r.e_ifrdy = (ird != 0); r.e_ifd    = ifd;
        r.e_dmrdy = (drd != 0); r.e_dmd    = dmd;
        r.e_sif   = (si != 0);  r.e_sdm    = (sd != 0);
        return r;
    endfunction

    task automatic drive(input vec_t x);
        bus2.if_req = x.if_req;   bus1.if_req = x.if_req;
        bus2.if_addr = x.if_addr; bus1.if_addr = x.if_addr;
        bus2.dm_req = x.dm_req;   bus1.dm_req = x.dm_req;
        bus2.dm_we = x.dm_we;     bus1.dm_we = x.dm_we;
        bus2.dm_addr = x.dm_addr; bus1.dm_addr = x.dm_addr;
        bus2.dm_wdata = x.dm_wdata; bus1.dm_wdata = x.dm_wdata;
        bus2.flush = x.flush;     bus1.flush = x.flush;
        bus2.mem_rdata = x.mem_rdata; bus1.mem_rdata = x.mem_rdata;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check_out(input vec_t x, input bit sel, input string tag);
        chk1 ({tag, ".mem_en"},    sel ? bus1.mem_en    : bus2.mem_en,    x.e_en);
        chk1 ({tag, ".mem_we"},    sel ? bus1.mem_we    : bus2.mem_we,    x.e_we);
        chk32({tag, ".mem_addr"},  sel ? bus1.mem_addr  : bus2.mem_addr,  x.e_addr);
        chk32({tag, ".mem_wdata"}, sel ? bus1.mem_wdata : bus2.mem_wdata, x.e_wdata);
        chk1 ({tag, ".if_ready"},  sel ? bus1.if_ready  : bus2.if_ready,  x.e_ifrdy);
        chk32({tag, ".if_rdata"},  sel ? bus1.if_rdata  : bus2.if_rdata,  x.e_ifd);
        chk1 ({tag, ".dm_ready"},  sel ? bus1.dm_ready  : bus2.dm_ready,  x.e_dmrdy);
        chk32({tag, ".dm_rdata"},  sel ? bus1.dm_rdata  : bus2.dm_rdata,  x.e_dmd);
        chk1 ({tag, ".stall_if"},  sel ? bus1.stall_if  : bus2.stall_if,  x.e_sif);
        chk1 ({tag, ".stall_dm"},  sel ? bus1.stall_dm  : bus2.stall_dm,  x.e_sdm);
    endtask

    // One row per clock cycle: inputs applied just after the edge, outputs sampled 1ns later.
    task automatic step(input vec_t x, input bit sel, input string tag);
        @(posedge clk);
        #1;
        drive(x);
        #1;
        check_out(x, sel, tag);
    endtask

    task automatic run_table(input bit sel, input string tag);
        foreach (tbl[i]) step(tbl[i], sel, $sformatf("%s%0d", tag, i));
        tbl.delete();
    endtask

    initial begin
        idle_v = v(0,0,0,0,0,0,0,G, 0,0,0,0,0,0,0,0,0,0);
        drive(idle_v);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check_out(idle_v, 1'b0, "reset2");
        check_out(idle_v, 1'b1, "reset1");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // WAIT_CYCLES=2: fetch, DM-over-IF priority, store, killed fetch, flush blocking a grant
        tbl.push_back(v(0,0,0,0,0,0,0,G,                        0,0,0,0,0,0,0,0,0,0));
        tbl.push_back(v(1,'h100,0,0,0,0,0,G,                    0,0,0,0,0,0,0,0,1,0));
        tbl.push_back(v(1,'h100,0,0,0,0,0,G,                    1,0,'h100,0,0,0,0,0,1,0));
        tbl.push_back(v(1,'h100,0,0,0,0,0,'hDEADBEEF,           0,0,'h100,0,0,0,0,0,1,0));
        tbl.push_back(v(1,'h100,0,0,0,0,0,G,                    0,0,'h100,0,1,'hDEADBEEF,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,G,                        0,0,'h100,0,0,'hDEADBEEF,0,0,0,0));
        tbl.push_back(v(1,'h104,1,0,'h200,0,0,G,                0,0,'h100,0,0,'hDEADBEEF,0,0,1,1));
        tbl.push_back(v(1,'h104,1,0,'h200,0,0,G,                1,0,'h200,0,0,'hDEADBEEF,0,0,1,1));
        tbl.push_back(v(1,'h104,1,0,'h200,0,0,'hCAFEF00D,       0,0,'h200,0,0,'hDEADBEEF,0,0,1,1));
        tbl.push_back(v(1,'h104,1,0,'h200,0,0,G,                0,0,'h200,0,0,'hDEADBEEF,1,'hCAFEF00D,1,0));
        tbl.push_back(v(1,'h104,0,0,0,0,0,G,                    1,0,'h104,0,0,'hDEADBEEF,0,'hCAFEF00D,1,0));
        tbl.push_back(v(1,'h104,0,0,0,0,0,'h11112222,           0,0,'h104,0,0,'hDEADBEEF,0,'hCAFEF00D,1,0));
        tbl.push_back(v(1,'h104,0,0,0,0,0,G,                    0,0,'h104,0,1,'h11112222,0,'hCAFEF00D,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,G,                        0,0,'h104,0,0,'h11112222,0,'hCAFEF00D,0,0));
        tbl.push_back(v(0,0,1,1,'h204,'h12345678,0,G,           0,0,'h104,0,0,'h11112222,0,'hCAFEF00D,0,1));
        tbl.push_back(v(0,0,1,1,'h204,'h12345678,0,G,           1,1,'h204,'h12345678,0,'h11112222,0,'hCAFEF00D,0,1));
        tbl.push_back(v(0,0,1,1,'h204,'h12345678,0,'h5555AAAA,  0,0,'h204,'h12345678,0,'h11112222,0,'hCAFEF00D,0,1));
        tbl.push_back(v(0,0,1,1,'h204,'h12345678,0,G,           0,0,'h204,'h12345678,0,'h11112222,1,'hCAFEF00D,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,G,                        0,0,'h204,'h12345678,0,'h11112222,0,'hCAFEF00D,0,0));
        tbl.push_back(v(1,'h108,0,0,0,0,0,G,                    0,0,'h204,'h12345678,0,'h11112222,0,'hCAFEF00D,1,0));
        tbl.push_back(v(1,'h108,0,0,0,0,0,G,                    1,0,'h108,'h12345678,0,'h11112222,0,'hCAFEF00D,1,0));
        tbl.push_back(v(1,'h108,0,0,0,0,1,'h0BADF00D,           0,0,'h108,'h12345678,0,'h11112222,0,'hCAFEF00D,1,0));
        tbl.push_back(v(1,'h300,0,0,0,0,0,G,                    0,0,'h108,'h12345678,0,'h0BADF00D,0,'hCAFEF00D,1,0));
        tbl.push_back(v(1,'h300,0,0,0,0,0,G,                    1,0,'h300,'h12345678,0,'h0BADF00D,0,'hCAFEF00D,1,0));
        tbl.push_back(v(1,'h300,0,0,0,0,0,'h30303030,           0,0,'h300,'h12345678,0,'h0BADF00D,0,'hCAFEF00D,1,0));
        tbl.push_back(v(1,'h300,0,0,0,0,0,G,                    0,0,'h300,'h12345678,1,'h30303030,0,'hCAFEF00D,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,G,                        0,0,'h300,'h12345678,0,'h30303030,0,'hCAFEF00D,0,0));
        tbl.push_back(v(1,'h400,0,0,0,0,1,G,                    0,0,'h300,'h12345678,0,'h30303030,0,'hCAFEF00D,1,0));
        tbl.push_back(v(1,'h400,0,0,0,0,0,G,                    0,0,'h300,'h12345678,0,'h30303030,0,'hCAFEF00D,1,0));
        tbl.push_back(v(1,'h400,0,0,0,0,0,G,                    1,0,'h400,'h12345678,0,'h30303030,0,'hCAFEF00D,1,0));
        tbl.push_back(v(1,'h400,0,0,0,0,0,'h40404040,           0,0,'h400,'h12345678,0,'h30303030,0,'hCAFEF00D,1,0));
        tbl.push_back(v(1,'h400,0,0,0,0,0,G,                    0,0,'h400,'h12345678,1,'h40404040,0,'hCAFEF00D,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,G,                        0,0,'h400,'h12345678,0,'h40404040,0,'hCAFEF00D,0,0));
        run_table(1'b0, "w2_");

        // Load at 0x208 aborted by reset in its last BUSY cycle
        step(v(0,0,1,0,'h208,0,0,G,          0,0,'h400,'h12345678,0,'h40404040,0,'hCAFEF00D,0,1), 1'b0, "rst_a");
        step(v(0,0,1,0,'h208,0,0,G,          1,0,'h208,0,0,'h40404040,0,'hCAFEF00D,0,1),         1'b0, "rst_b");
        step(v(0,0,1,0,'h208,0,0,'h20820820, 0,0,'h208,0,0,'h40404040,0,'hCAFEF00D,0,1),         1'b0, "rst_c");
        #1 rst_n = 1'b0;
        #1 check_out(v(0,0,1,0,'h208,0,0,'h20820820, 0,0,0,0,0,0,0,0,0,1), 1'b0, "rst_async");
        @(posedge clk);
        #1;
        drive(idle_v);
        rst_n = 1'b1;

        tbl.push_back(v(0,0,0,0,0,0,0,G,                0,0,0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,G,                0,0,0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,G,                0,0,0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,1,0,'h20C,0,0,G,            0,0,0,0,0,0,0,0,0,1));
        tbl.push_back(v(0,0,1,0,'h20C,0,0,G,            1,0,'h20C,0,0,0,0,0,0,1));
        tbl.push_back(v(0,0,1,0,'h20C,0,0,'h20C20C20,   0,0,'h20C,0,0,0,0,0,0,1));
        tbl.push_back(v(0,0,1,0,'h20C,0,0,G,            0,0,'h20C,0,0,0,1,'h20C20C20,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,G,                0,0,'h20C,0,0,0,0,'h20C20C20,0,0));
        run_table(1'b0, "post_rst");

        @(posedge clk);
        #1 rst_n = 1'b0;
        drive(idle_v);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // WAIT_CYCLES=1, both ports requesting continuously: accesses alternate every two cycles
        tbl.push_back(v(1,'h500,1,0,'h600,0,0,G,          0,0,0,0,0,0,0,0,1,1));
        tbl.push_back(v(1,'h500,1,0,'h600,0,0,'h66666666, 1,0,'h600,0,0,0,0,0,1,1));
        tbl.push_back(v(1,'h500,1,0,'h600,0,0,G,          0,0,'h600,0,0,0,1,'h66666666,1,0));
        tbl.push_back(v(1,'h500,1,0,'h604,0,0,'h55555555, 1,0,'h500,0,0,0,0,'h66666666,1,1));
        tbl.push_back(v(1,'h500,1,0,'h604,0,0,G,          0,0,'h500,0,1,'h55555555,0,'h66666666,0,1));
        tbl.push_back(v(1,'h504,1,0,'h604,0,0,'h66660004, 1,0,'h604,0,0,'h55555555,0,'h66666666,1,1));
        tbl.push_back(v(1,'h504,1,0,'h604,0,0,G,          0,0,'h604,0,0,'h55555555,1,'h66660004,1,0));
        tbl.push_back(v(1,'h504,0,0,0,0,0,'h55550004,     1,0,'h504,0,0,'h55555555,0,'h66660004,1,0));
        tbl.push_back(v(1,'h504,0,0,0,0,0,G,              0,0,'h504,0,1,'h55550004,0,'h66660004,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,G,                  0,0,'h504,0,0,'h55550004,0,'h66660004,0,0));
        run_table(1'b1, "w1_");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
